dcache_assoc_mem: RTL and testbench
===================================

DCACHE_ASSOC_MEM -- requirements
Module: dcache_assoc_mem

Interface
REQ-001 The block SHALL have parameter SETS, default 64, number of sets (power of 2, >=2).
REQ-002 The block SHALL have parameter WAYS, default 2, associativity (power of 2, >=2).
REQ-003 The block SHALL have parameter TAG_W, default 22, tag width.
REQ-004 The block SHALL have parameter DATA_W, default 64, line data width.
REQ-005 The block SHALL have the port clock  in  1  clock; all state changes on the rising edge.
REQ-006 The block SHALL have the port reset  in  1  reset, synchronous, active-high.
REQ-007 The block SHALL have the ports rd_en in 1, rd_idx in IDX_W, rd_tag in TAG_W: lookup request, with IDX_W=$clog2(SETS).
REQ-008 The block SHALL have the ports rd_data out DATA_W, rd_hit out 1, rd_way out $clog2(WAYS): combinational lookup result.
REQ-009 The block SHALL have the ports wr1_en in 1, wr1_idx in IDX_W, wr1_tag in TAG_W, wr1_data in DATA_W: fill port (line from memory).
REQ-010 The block SHALL have the ports wr2_en in 1, wr2_idx in IDX_W, wr2_tag in TAG_W, wr2_data in DATA_W, wr2_hit out 1: store port.
REQ-011 The block SHALL have the ports evict_valid out 1, evict_idx out IDX_W, evict_tag out TAG_W, evict_data out DATA_W: registered dirty-victim writeback.

Function
REQ-012 The block SHALL assert rd_hit when some way w of set rd_idx is valid with tag == rd_tag, SHALL drive rd_way=w and rd_data=data of w, and SHALL drive rd_data=0 and rd_way=0 on a miss.
REQ-013 The block SHALL compute wr2_hit combinationally by the same rule on wr2_idx/wr2_tag.
REQ-014 The block SHALL make writes visible to lookups from the cycle after the write edge, with no same-cycle bypass.
REQ-015 On wr1_en with a tag hit, the block SHALL overwrite that way's data in place and SHALL clear its dirty bit.
REQ-016 On wr1_en with a tag miss, the block SHALL allocate a victim (the lowest-index invalid way, else the LRU way), write tag and data, set valid and clear dirty.
REQ-017 On wr2_en with wr2_hit, the block SHALL write wr2_data into the hit way and set its dirty bit.
REQ-018 On wr2_en without a hit, the block SHALL change no state.
REQ-019 The block SHALL keep true LRU per set as WAYS age counters of $clog2(WAYS) bits each; on an access the touched way's age SHALL become 0 and ways younger than its old age SHALL increment; the LRU way is the one with age WAYS-1.
REQ-020 The block SHALL update age on a rd_en hit, a wr2 hit and any wr1, applied in the order read, wr2, wr1, so that wr1 ends most-recent.
REQ-021 When wr1 and wr2 hit the same set and same tag in one cycle, wr1 SHALL win: the line gets wr1_data with dirty clear, and wr2 is dropped while wr2_hit still reflects pre-edge state.
REQ-022 When wr1 and wr2 target the same set with different tags, both SHALL apply; if the wr1 victim equals the wr2 hit way, wr1 SHALL win and wr2 is dropped.
REQ-023 When a wr1 allocation displaces a valid dirty line, the block SHALL on the next cycle assert evict_valid for exactly 1 cycle with that line's pre-edge idx, tag and data; otherwise evict_valid SHALL be 0.

Reset
REQ-024 Reset SHALL clear all valid and dirty bits, set way w's age to w in every set, and clear evict_valid, evict_idx, evict_tag and evict_data to 0.
REQ-025 Reset SHALL leave data and tag arrays uninitialised; a write in a reset cycle SHALL be ignored.

Configuration
REQ-026 With DCACHE_WRITEBACK_EN defined, the block SHALL implement dirty bits and the eviction outputs as above.
REQ-027 Without DCACHE_WRITEBACK_EN, the block SHALL have no dirty storage, SHALL tie evict_valid to 0 and all evict_* buses to 0, and SHALL keep store-hit data and LRU behaviour identical.

Structure
REQ-028 A shared package dcache_pkg SHALL hold default parameter constants and a line-state typedef (valid, dirty, tag).
REQ-029 The block SHALL use one sub-module, dcache_lru_set, holding the per-set age update and victim select, instantiated per set.

Verification
REQ-030 The bench SHALL cover: reset, then rd idx 5 tag 0x1 -> rd_hit=0, rd_data=0.
REQ-031 The bench SHALL cover: fill idx 5 tag 0xA data 0x11, then tag 0xB data 0x22 -> both hit next cycle, on ways 0 and 1.
REQ-032 The bench SHALL cover, with WAYS=2: read hit on tag 0xA, then fill tag 0xC -> tag 0xB is evicted and tags 0xA and 0xC hit.
REQ-033 The bench SHALL cover: store tag 0xA data 0x33, then fill displacing it -> evict_valid=1 for 1 cycle with idx 5, tag 0xA, data 0x33; with the macro undefined, evict_valid stays 0.
REQ-034 The bench SHALL cover: same-cycle wr1 and wr2 to idx 5 tag 0xA -> data equals wr1_data, and a later eviction of that line gives no evict_valid.
REQ-035 The bench SHALL cover: store miss idx 7 tag 0x9 -> wr2_hit=0 and later reads of idx 7 all miss.

Source files
------------

// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : shared defaults, line-state type and tag-match helper
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

  localparam int unsigned DEF_SETS   = 64;
  localparam int unsigned DEF_WAYS   = 2;
  localparam int unsigned DEF_TAG_W  = 22;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned MAX_TAG_W  = 64;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } line_state_t;

  function automatic logic line_match(input line_state_t line,
                                      input logic [MAX_TAG_W-1:0] tag);
    return line.valid && (line.tag == tag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_lru_set.sv
// ============================================================================
// dcache_lru_set : per-set true-LRU age counters and victim selection
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_lru_set
  import dcache_pkg::*;
#(
  parameter  int WAYS  = DEF_WAYS,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WAYS-1:0]  valid,
  input  logic             rd_touch,
  input  logic [WAY_W-1:0] rd_way,
  input  logic             wr2_touch,
  input  logic [WAY_W-1:0] wr2_way,
  input  logic             wr1_touch,
  input  logic [WAY_W-1:0] wr1_way,
  output logic [WAY_W-1:0] victim
);

  logic [WAYS-1:0][WAY_W-1:0] age_q, age_d;
  logic                       invalid_found;

  function automatic logic [WAYS-1:0][WAY_W-1:0] touch(
      input logic [WAYS-1:0][WAY_W-1:0] ages,
      input logic [WAY_W-1:0]           way);
    logic [WAYS-1:0][WAY_W-1:0] nxt;
    nxt = ages;
    for (int i = 0; i < WAYS; i++) begin
      if (i == int'(way)) begin
        nxt[i] = '0;
      end else if (ages[i] < ages[way]) begin
        nxt[i] = ages[i] + 1'b1;
      end
    end
    return nxt;
  endfunction

  // Fill is applied last so it always ends most-recent.
  always_comb begin
    age_d = age_q;
    if (rd_touch)  age_d = touch(age_d, rd_way);
    if (wr2_touch) age_d = touch(age_d, wr2_way);
    if (wr1_touch) age_d = touch(age_d, wr1_way);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) begin
        age_q[w] <= WAY_W'(w);
      end
    end else begin
      age_q <= age_d;
    end
  end

  always_comb begin
    victim        = '0;
    invalid_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!invalid_found && !valid[w]) begin
        victim        = WAY_W'(w);
        invalid_found = 1'b1;
      end
    end
    if (!invalid_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_assoc_mem.sv
// ============================================================================
// dcache_assoc_mem : set-associative data-cache array, fill + store ports
// Optional dirty tracking / victim writeback under DCACHE_WRITEBACK_EN
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_assoc_mem
  import dcache_pkg::*;
#(
  parameter  int SETS   = DEF_SETS,
  parameter  int WAYS   = DEF_WAYS,
  parameter  int TAG_W  = DEF_TAG_W,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit,
  output logic [WAY_W-1:0]  rd_way,
  input  logic              wr1_en,
  input  logic [IDX_W-1:0]  wr1_idx,
  input  logic [TAG_W-1:0]  wr1_tag,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr2_en,
  input  logic [IDX_W-1:0]  wr2_idx,
  input  logic [TAG_W-1:0]  wr2_tag,
  input  logic [DATA_W-1:0] wr2_data,
  output logic              wr2_hit,
  output logic              evict_valid,
  output logic [IDX_W-1:0]  evict_idx,
  output logic [TAG_W-1:0]  evict_tag,
  output logic [DATA_W-1:0] evict_data
);

  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0] dirty_vis;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [DATA_W-1:0]         data_q [SETS][WAYS];

  logic [SETS-1:0][WAY_W-1:0] set_victim;
  logic [WAY_W-1:0]           victim_way;
  logic [WAY_W-1:0]           wr2_way;
  logic                       wr1_hit;
  logic [WAY_W-1:0]           wr1_hit_way;
  logic [WAY_W-1:0]           wr1_way;
  logic                       wr1_apply;
  logic                       wr2_apply;

  function automatic line_state_t make_line(input logic v, input logic d,
                                            input logic [TAG_W-1:0] t);
    line_state_t l;
    l.valid = v;
    l.dirty = d;
    l.tag   = MAX_TAG_W'(t);
    return l;
  endfunction

  // Tags are unique within a set, so at most one way matches per lookup.
  always_comb begin
    rd_hit      = 1'b0;
    rd_way      = '0;
    rd_data     = '0;
    wr2_hit     = 1'b0;
    wr2_way     = '0;
    wr1_hit     = 1'b0;
    wr1_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!rd_hit && line_match(make_line(valid_q[rd_idx][w], dirty_vis[rd_idx][w],
                                          tag_q[rd_idx][w]), MAX_TAG_W'(rd_tag))) begin
        rd_hit  = 1'b1;
        rd_way  = WAY_W'(w);
        rd_data = data_q[rd_idx][w];
      end
      if (!wr2_hit && line_match(make_line(valid_q[wr2_idx][w], dirty_vis[wr2_idx][w],
                                           tag_q[wr2_idx][w]), MAX_TAG_W'(wr2_tag))) begin
        wr2_hit = 1'b1;
        wr2_way = WAY_W'(w);
      end
      if (!wr1_hit && line_match(make_line(valid_q[wr1_idx][w], dirty_vis[wr1_idx][w],
                                           tag_q[wr1_idx][w]), MAX_TAG_W'(wr1_tag))) begin
        wr1_hit     = 1'b1;
        wr1_hit_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = set_victim[wr1_idx];
  assign wr1_way    = wr1_hit ? wr1_hit_way : victim_way;
  assign wr1_apply  = wr1_en && !reset;
  // A store colliding with the fill's target way loses to the fill.
  assign wr2_apply  = wr2_en && wr2_hit && !reset &&
                      !(wr1_apply && (wr1_idx == wr2_idx) && (wr1_way == wr2_way));

  always_comb begin
    valid_d = valid_q;
    if (wr1_apply) valid_d[wr1_idx][wr1_way] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr2_apply) begin
      data_q[wr2_idx][wr2_way] <= wr2_data;
    end
    if (wr1_apply) begin
      tag_q[wr1_idx][wr1_way]  <= wr1_tag;
      data_q[wr1_idx][wr1_way] <= wr1_data;
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_set
    dcache_lru_set #(
      .WAYS (WAYS)
    ) u_lru (
      .clock     (clock),
      .reset     (reset),
      .valid     (valid_q[s]),
      .rd_touch  (rd_en && rd_hit && (rd_idx == IDX_W'(s))),
      .rd_way    (rd_way),
      .wr2_touch (wr2_en && wr2_hit && (wr2_idx == IDX_W'(s))),
      .wr2_way   (wr2_way),
      .wr1_touch (wr1_en && (wr1_idx == IDX_W'(s))),
      .wr1_way   (wr1_way),
      .victim    (set_victim[s])
    );
  end

`ifdef DCACHE_WRITEBACK_EN
  logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;
  logic                      evict_valid_q, evict_valid_d;
  logic [IDX_W-1:0]          evict_idx_q, evict_idx_d;
  logic [TAG_W-1:0]          evict_tag_q, evict_tag_d;
  logic [DATA_W-1:0]         evict_data_q, evict_data_d;

  assign dirty_vis = dirty_q;

  always_comb begin
    dirty_d = dirty_q;
    if (wr2_apply) dirty_d[wr2_idx][wr2_way] = 1'b1;
    if (wr1_apply) dirty_d[wr1_idx][wr1_way] = 1'b0;
  end

  // Victim fields are captured from pre-edge state before the fill overwrites them.
  always_comb begin
    evict_valid_d = wr1_apply && !wr1_hit && valid_q[wr1_idx][victim_way] &&
                    dirty_q[wr1_idx][victim_way];
    evict_idx_d   = evict_idx_q;
    evict_tag_d   = evict_tag_q;
    evict_data_d  = evict_data_q;
    if (evict_valid_d) begin
      evict_idx_d  = wr1_idx;
      evict_tag_d  = tag_q[wr1_idx][victim_way];
      evict_data_d = data_q[wr1_idx][victim_way];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dirty_q       <= '0;
      evict_valid_q <= 1'b0;
      evict_idx_q   <= '0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
    end else begin
      dirty_q       <= dirty_d;
      evict_valid_q <= evict_valid_d;
      evict_idx_q   <= evict_idx_d;
      evict_tag_q   <= evict_tag_d;
      evict_data_q  <= evict_data_d;
    end
  end

  assign evict_valid = evict_valid_q;
  assign evict_idx   = evict_idx_q;
  assign evict_tag   = evict_tag_q;
  assign evict_data  = evict_data_q;
`else
  assign dirty_vis   = '0;
  assign evict_valid = 1'b0;
  assign evict_idx   = '0;
  assign evict_tag   = '0;
  assign evict_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_assoc_mem.sv
// ============================================================================
// tb_dcache_assoc_mem : table-driven bench for dcache_assoc_mem (2-way, 64 sets)
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_assoc_mem;

  localparam int SETS   = 64;
  localparam int WAYS   = 2;
  localparam int TAG_W  = 22;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 6;
  localparam int WAY_W  = 1;
  localparam int NVEC   = 29;

`ifdef DCACHE_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;
  logic [WAY_W-1:0]  rd_way;
  logic              wr1_en;
  logic [IDX_W-1:0]  wr1_idx;
  logic [TAG_W-1:0]  wr1_tag;
  logic [DATA_W-1:0] wr1_data;
  logic              wr2_en;
  logic [IDX_W-1:0]  wr2_idx;
  logic [TAG_W-1:0]  wr2_tag;
  logic [DATA_W-1:0] wr2_data;
  logic              wr2_hit;
  logic              evict_valid;
  logic [IDX_W-1:0]  evict_idx;
  logic [TAG_W-1:0]  evict_tag;
  logic [DATA_W-1:0] evict_data;

  always #5 clock = ~clock;

  dcache_assoc_mem #(
    .SETS   (SETS),
    .WAYS   (WAYS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .rd_hit      (rd_hit),
    .rd_way      (rd_way),
    .wr1_en      (wr1_en),
    .wr1_idx     (wr1_idx),
    .wr1_tag     (wr1_tag),
    .wr1_data    (wr1_data),
    .wr2_en      (wr2_en),
    .wr2_idx     (wr2_idx),
    .wr2_tag     (wr2_tag),
    .wr2_data    (wr2_data),
    .wr2_hit     (wr2_hit),
    .evict_valid (evict_valid),
    .evict_idx   (evict_idx),
    .evict_tag   (evict_tag),
    .evict_data  (evict_data)
  );

  typedef struct {
    logic              re;
    logic [IDX_W-1:0]  ri;
    logic [TAG_W-1:0]  rt;
    logic              w1;
    logic [IDX_W-1:0]  w1i;
    logic [TAG_W-1:0]  w1t;
    logic [DATA_W-1:0] w1d;
    logic              w2;
    logic [IDX_W-1:0]  w2i;
    logic [TAG_W-1:0]  w2t;
    logic [DATA_W-1:0] w2d;
    logic              eh;
    logic [WAY_W-1:0]  ew;
    logic [DATA_W-1:0] ed;
    logic              ew2h;
    logic              ee;
  } vec_t;

  vec_t vecs [NVEC];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t V(input bit re, input int ri, input int rt,
                             input bit w1, input int w1i, input int w1t, input longint w1d,
                             input bit w2, input int w2i, input int w2t, input longint w2d,
                             input bit eh, input int ew, input longint ed,
                             input bit ew2h, input bit ee);
    vec_t v;
    v.re = re;  v.ri = IDX_W'(ri);   v.rt = TAG_W'(rt);
    v.w1 = w1;  v.w1i = IDX_W'(w1i); v.w1t = TAG_W'(w1t); v.w1d = DATA_W'(w1d);
    v.w2 = w2;  v.w2i = IDX_W'(w2i); v.w2t = TAG_W'(w2t); v.w2d = DATA_W'(w2d);
    v.eh = eh;  v.ew = WAY_W'(ew);   v.ed = DATA_W'(ed);
    v.ew2h = ew2h; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; rd_idx = '0; rd_tag = '0;
    wr1_en = 1'b0; wr1_idx = '0; wr1_tag = '0; wr1_data = '0;
    wr2_en = 1'b0; wr2_idx = '0; wr2_tag = '0; wr2_data = '0;
  endtask

  initial begin
    // Index 5 holds the main scenario; 7 is the store-miss set; 9 the collision set.
    //          rd            wr1                   wr2                   expected hit/way/data wr2h ev
    vecs[0]  = V(1,5,'h1,  0,0,0,0,            0,0,0,0,              0,0,0,     0,0);
    vecs[1]  = V(1,5,'hA,  1,5,'hA,'h11,       0,0,0,0,              0,0,0,     0,0);
    vecs[2]  = V(1,5,'hA,  1,5,'hB,'h22,       0,0,0,0,              1,0,'h11,  0,0);
    vecs[3]  = V(1,5,'hB,  0,0,0,0,            0,0,0,0,              1,1,'h22,  0,0);
    vecs[4]  = V(1,5,'hA,  0,0,0,0,            0,0,0,0,              1,0,'h11,  0,0);
    vecs[5]  = V(1,5,'hA,  1,5,'hC,'h44,       0,0,0,0,              1,0,'h11,  0,0);
    vecs[6]  = V(1,5,'hB,  0,0,0,0,            0,0,0,0,              0,0,0,     0,0);
    vecs[7]  = V(1,5,'hC,  0,0,0,0,            0,0,0,0,              1,1,'h44,  0,0);
    vecs[8]  = V(1,5,'hA,  0,0,0,0,            1,5,'hA,'h33,         1,0,'h11,  1,0);
    vecs[9]  = V(1,5,'hA,  0,0,0,0,            0,0,0,0,              1,0,'h33,  0,0);
    vecs[10] = V(1,5,'hC,  0,0,0,0,            0,0,0,0,              1,1,'h44,  0,0);
    vecs[11] = V(0,5,'hA,  1,5,'hD,'h55,       0,0,0,0,              1,0,'h33,  0,0);
    vecs[12] = V(1,5,'hD,  0,0,0,0,            0,0,0,0,              1,0,'h55,  0,1);
    vecs[13] = V(1,5,'hA,  0,0,0,0,            0,0,0,0,              0,0,0,     0,0);
    vecs[14] = V(0,5,'hC,  1,5,'hA,'h66,       0,0,0,0,              1,1,'h44,  0,0);
    vecs[15] = V(1,5,'hA,  1,5,'hA,'h77,       1,5,'hA,'h88,         1,1,'h66,  1,0);
    vecs[16] = V(1,5,'hA,  0,0,0,0,            0,0,0,0,              1,1,'h77,  0,0);
    vecs[17] = V(1,5,'hD,  0,0,0,0,            0,0,0,0,              1,0,'h55,  0,0);
    vecs[18] = V(0,5,'hD,  1,5,'hE,'h99,       0,0,0,0,              1,0,'h55,  0,0);
    vecs[19] = V(1,5,'hE,  0,0,0,0,            0,0,0,0,              1,1,'h99,  0,0);
    vecs[20] = V(1,5,'hA,  0,0,0,0,            0,0,0,0,              0,0,0,     0,0);
    vecs[21] = V(1,7,'h9,  0,0,0,0,            1,7,'h9,'h123,        0,0,0,     0,0);
    vecs[22] = V(1,7,'h9,  0,0,0,0,            0,0,0,0,              0,0,0,     0,0);
    vecs[23] = V(1,5,'hE,  0,0,0,0,            0,0,0,0,              1,1,'h99,  0,0);
    vecs[24] = V(1,9,'h1,  1,9,'h1,'h1,        0,0,0,0,              0,0,0,     0,0);
    vecs[25] = V(0,9,'h1,  1,9,'h2,'h2,        0,0,0,0,              1,0,'h1,   0,0);
    vecs[26] = V(0,9,'h2,  1,9,'h3,'h3,        1,9,'h1,'h5,          1,1,'h2,   1,0);
    vecs[27] = V(1,9,'h3,  0,0,0,0,            0,0,0,0,              1,0,'h3,   0,0);
    vecs[28] = V(1,9,'h1,  0,0,0,0,            0,0,0,0,              0,0,0,     0,0);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset evict_valid", 64'(evict_valid), 64'd0);
    chk("reset evict_idx",   64'(evict_idx),   64'd0);
    chk("reset evict_tag",   64'(evict_tag),   64'd0);
    chk("reset evict_data",  64'(evict_data),  64'd0);
    @(posedge clock);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      rd_en  = vecs[i].re;  rd_idx  = vecs[i].ri;  rd_tag  = vecs[i].rt;
      wr1_en = vecs[i].w1;  wr1_idx = vecs[i].w1i; wr1_tag = vecs[i].w1t; wr1_data = vecs[i].w1d;
      wr2_en = vecs[i].w2;  wr2_idx = vecs[i].w2i; wr2_tag = vecs[i].w2t; wr2_data = vecs[i].w2d;
      @(negedge clock);
      chk($sformatf("v%0d rd_hit", i),  64'(rd_hit),  64'(vecs[i].eh));
      chk($sformatf("v%0d rd_way", i),  64'(rd_way),  64'(vecs[i].ew));
      chk($sformatf("v%0d rd_data", i), 64'(rd_data), 64'(vecs[i].ed));
      chk($sformatf("v%0d wr2_hit", i), 64'(wr2_hit), 64'(vecs[i].ew2h));
      chk($sformatf("v%0d evict_valid", i), 64'(evict_valid), 64'(vecs[i].ee && WB));
      if (vecs[i].ee && WB) begin
        chk($sformatf("v%0d evict_idx", i),  64'(evict_idx),  64'd5);
        chk($sformatf("v%0d evict_tag", i),  64'(evict_tag),  64'hA);
        chk($sformatf("v%0d evict_data", i), 64'(evict_data), 64'h33);
      end
      @(posedge clock);
      #1;
    end

    // Reset mid-run: a fill presented during reset must be ignored and evict regs cleared.
    idle_inputs();
    reset = 1'b1;
    wr1_en = 1'b1; wr1_idx = 6'd5; wr1_tag = 22'hF; wr1_data = 64'h1;
    rd_en = 1'b1; rd_idx = 6'd5; rd_tag = 22'hF;
    @(posedge clock);
    #1 reset = 1'b0;
    wr1_en = 1'b0;
    @(negedge clock);
    chk("post-reset rd_hit tag F", 64'(rd_hit),      64'd0);
    chk("post-reset evict_valid",  64'(evict_valid), 64'd0);
    chk("post-reset evict_idx",    64'(evict_idx),   64'd0);
    chk("post-reset evict_tag",    64'(evict_tag),   64'd0);
    chk("post-reset evict_data",   64'(evict_data),  64'd0);
    rd_tag = 22'hE;
    #1;
    chk("post-reset rd_hit tag E", 64'(rd_hit),  64'd0);
    chk("post-reset rd_data",      64'(rd_data), 64'd0);
    @(posedge clock);
    #1;
    wr1_en = 1'b1; wr1_idx = 6'd5; wr1_tag = 22'h1; wr1_data = 64'hAB;
    @(posedge clock);
    #1;
    wr1_en = 1'b0;
    rd_tag = 22'h1;
    @(negedge clock);
    chk("refill rd_hit",  64'(rd_hit),  64'd1);
    chk("refill rd_way",  64'(rd_way),  64'd0);
    chk("refill rd_data", 64'(rd_data), 64'hAB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
